fir_decimator: RTL

- Sits directly downstream of the FIR filter cores (FIR_symmetric / FIR_adderTree / FIR_filter_DirectForm).
- Consumes one filtered sample per qualified clock and reduces the rate by DECIM, either by plain down-sampling or by block averaging.
- Buffers the decimated samples in a small FIFO with a valid/ready output handshake, so a slower consumer (DAC interface, logger, bus bridge) can drain them.

---
 rtl/fir_decim_pkg.sv | 12 +
 rtl/fir_decimator_fifo.sv | 46 ++++
 rtl/fir_decimator.sv | 70 +++++++
 3 files changed

// File: rtl/fir_decim_pkg.sv
// Shared constants and sample/accumulator types for the FIR decimator slice.
// The default sample width matches the FIR output_signal_y width.
package fir_decim_pkg;
  localparam int DEF_WIDTH      = 16;
  localparam int DEF_DECIM      = 4;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DECIM_LOG2     = $clog2(DEF_DECIM);
  localparam int FIFO_AW        = $clog2(DEF_FIFO_DEPTH);

  typedef logic signed [DEF_WIDTH-1:0]            sample_t;
  typedef logic signed [DEF_WIDTH+DECIM_LOG2-1:0] acc_t;
endpackage

// File: rtl/fir_decimator_fifo.sv
// First-word-fall-through FIFO with registered storage; head is valid while !empty.
module sample_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the write lands in, so push at full succeeds with pop.
  assign do_push = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/fir_decimator.sv
// Rate reduction by DECIM (down-sample or block mean) feeding a valid/ready FIFO.
module fir_decimator
  import fir_decim_pkg::*;
#(
  parameter int width      = DEF_WIDTH,
  parameter int DECIM      = DEF_DECIM,
  parameter int AVERAGE    = 0,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [width-1:0]       sample_in,
  input  logic                          sample_valid,
  output logic signed [width-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  input  logic                          overflow_clr
);
  localparam int DL2 = $clog2(DECIM);
  typedef logic signed [width+DL2-1:0] sum_t;

  logic [DL2-1:0]   phase;
  sum_t             acc, sum_next, mean;
  logic             first, last, push, pop, empty, full;
  logic [width-1:0] push_data, head_data, hold;

  assign first    = (phase == '0);
  assign last     = (phase == DL2'(DECIM-1));
  assign sum_next = acc + sum_t'(sample_in);
  // Arithmetic shift floors toward -inf; the mean always fits in width bits.
  assign mean     = sum_next >>> DL2;

  assign push      = sample_valid & ((AVERAGE != 0) ? last : first);
  assign push_data = (AVERAGE != 0) ? mean[width-1:0] : sample_in;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign out_data  = empty ? hold : head_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase    <= '0;
      acc      <= '0;
      hold     <= '0;
      overflow <= 1'b0;
    end else begin
      if (sample_valid) begin
        phase <= last ? '0 : phase + DL2'(1);
        acc   <= first ? sum_t'(sample_in) : sum_next;
      end
      // Keeps out_data steady on the last popped value once the FIFO runs dry.
      if (pop) hold <= head_data;
      if (push & full & ~pop) overflow <= 1'b1;
      else if (overflow_clr)  overflow <= 1'b0;
    end
  end

  sample_fifo #(.DW(width), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .empty     (empty),
    .full      (full),
    .level     (fill_level)
  );
endmodule
